// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store sequencer: widths, FSM encoding, lanes.
package mem_access_unit_pkg;

  localparam int MAU_DATA_W = 24;
  localparam int MAU_ADDR_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] LANE_0       = 2'd0;
  localparam logic [1:0] LANE_1       = 2'd1;
  localparam logic [1:0] LANE_2       = 2'd2;
  localparam logic [1:0] LANE_ILLEGAL = 2'd3;

  // A byte request naming the fourth (non-existent) lane is rejected.
  function automatic logic is_illegal(input logic is_byte, input logic [1:0] lane);
    return is_byte && (lane == LANE_ILLEGAL);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bundle of the load/store sequencer.
//
// Handshake: the CPU raises req with all request fields stable; the unit
// samples them at a rising edge only while busy=0. busy stays high until
// the operation ends; done pulses for exactly one cycle (error alongside it
// for an illegal lane). A req seen while busy=1 is dropped, never queued.
interface mem_access_unit_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 24
);
  logic              req;
  logic              req_write;
  logic              req_byte;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_lane;
  logic [DATA_W-1:0] store_data;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] load_data;

  modport master (
    output req, req_write, req_byte, req_signed, req_addr, req_lane, store_data,
    input  busy, done, error, load_data
  );

  modport slave (
    input  req, req_write, req_byte, req_signed, req_addr, req_lane, store_data,
    output busy, done, error, load_data
  );
endinterface

// File: rtl/mem_access_unit_byte_lane_unit.sv
// Combinational byte-lane datapath: load extraction/extension and store merge.
module byte_lane_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = MAU_DATA_W
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_lane,
  input  logic              i_byte,
  input  logic              i_signed,
  input  logic [7:0]        i_store_byte,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_merged
);

  logic [7:0] w_sel;
  logic       w_fill;

  // Pick the addressed byte and extend it; word loads pass straight through.
  always_comb begin
    w_sel = 8'h00;
    case (i_lane)
      LANE_0:  w_sel = i_word[7:0];
      LANE_1:  w_sel = i_word[15:8];
      LANE_2:  w_sel = i_word[23:16];
      default: w_sel = 8'h00;
    endcase
    w_fill = i_signed & w_sel[7];
    if (i_byte) o_load = {{(DATA_W-8){w_fill}}, w_sel};
    else        o_load = i_word;
  end

  // Replace only the addressed byte; other lanes keep the word read back.
  always_comb begin
    o_merged = i_word;
    case (i_lane)
      LANE_0:  o_merged[7:0]   = i_store_byte;
      LANE_1:  o_merged[15:8]  = i_store_byte;
      LANE_2:  o_merged[23:16] = i_store_byte;
      default: o_merged        = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the execute stage and DataMemory.
// Byte stores are read-modify-write because DataMemory writes whole words.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = MAU_DATA_W,
  parameter int ADDR_W = MAU_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  mem_access_unit_if.slave  cpu,
  input  logic [DATA_W-1:0] i_mem_read_data,
  output logic [ADDR_W-1:0] o_mem_adresa,
  output logic [DATA_W-1:0] o_mem_write_data,
  output logic              o_mem_write,
  output logic              o_mem_read,
  output state_t            o_dbg_state
);

  state_t            r_state;
  state_t            w_next_state;

  logic              r_write;
  logic              r_byte;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_lane;
  logic [DATA_W-1:0] r_store_data;
  logic [DATA_W-1:0] r_rd_word;
  logic [DATA_W-1:0] r_load_data;
  logic              r_err;

  logic              w_illegal;
  logic [DATA_W-1:0] w_lane_word;
  logic [DATA_W-1:0] w_load_ext;
  logic [DATA_W-1:0] w_merged;

  assign w_illegal   = is_illegal(r_byte, r_lane);
  // Loads extract from live read data; the merge works on the captured word.
  assign w_lane_word = (r_state == ST_WRITE) ? r_rd_word : i_mem_read_data;

  byte_lane_unit #(.DATA_W(DATA_W)) u_lane (
    .i_word       (w_lane_word),
    .i_lane       (r_lane),
    .i_byte       (r_byte),
    .i_signed     (r_signed),
    .i_store_byte (r_store_data[7:0]),
    .o_load       (w_load_ext),
    .o_merged     (w_merged)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (cpu.req) w_next_state = ST_ACCESS;
      ST_ACCESS: begin
        if (w_illegal)              w_next_state = ST_DONE;
        else if (r_write && r_byte) w_next_state = ST_WRITE;
        else                        w_next_state = ST_DONE;
      end
      ST_WRITE:  w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; memory strobes vanish the moment reset hits.
  always_comb begin
    o_mem_read       = 1'b0;
    o_mem_write      = 1'b0;
    o_mem_write_data = '0;
    case (r_state)
      ST_ACCESS: begin
        if (!w_illegal) begin
          if (r_write && !r_byte) begin
            o_mem_write      = 1'b1;
            o_mem_write_data = r_store_data;
          end else begin
            o_mem_read = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        o_mem_write      = 1'b1;
        o_mem_write_data = w_merged;
      end
      default: ;
    endcase
  end

  // Request latch, read capture, load result and error flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_write      <= 1'b0;
      r_byte       <= 1'b0;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_lane       <= 2'd0;
      r_store_data <= '0;
      r_rd_word    <= '0;
      r_load_data  <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu.req) begin
            r_write      <= cpu.req_write;
            r_byte       <= cpu.req_byte;
            r_signed     <= cpu.req_signed;
            r_addr       <= cpu.req_addr;
            r_lane       <= cpu.req_lane;
            r_store_data <= cpu.store_data;
            r_err        <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (w_illegal)    r_err       <= 1'b1;
          else if (!r_write) r_load_data <= w_load_ext;
          else if (r_byte)   r_rd_word   <= i_mem_read_data;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_adresa  = r_addr;
  assign cpu.busy      = (r_state != ST_IDLE);
  assign cpu.done      = (r_state == ST_DONE);
  assign cpu.error     = (r_state == ST_DONE) && r_err;
  assign cpu.load_data = r_load_data;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small behavioural DataMemory.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [23:0] mem_rdata;
  logic [23:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  state_t      dbg_state;
  logic [23:0] mem [0:15];

  int n_tests;
  int n_fail;
  int overlap;

  mem_access_unit_if #(.DATA_W(24), .ADDR_W(24)) cpu_if ();

  mem_access_unit dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .cpu              (cpu_if.slave),
    .i_mem_read_data  (mem_rdata),
    .o_mem_adresa     (mem_addr),
    .o_mem_write_data (mem_wdata),
    .o_mem_write      (mem_write),
    .o_mem_read       (mem_read),
    .o_dbg_state      (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory model: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr[3:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[3:0]] <= mem_wdata;

  always @(negedge clk) if (mem_read && mem_write) overlap++;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and watch it to completion (bounded at 10 cycles).
  task automatic run_op(input logic wr, input logic by, input logic sg,
                        input logic [23:0] addr, input logic [1:0] lane,
                        input logic [23:0] sd,
                        output int lat, output int nrd, output int nwr,
                        output logic err, output logic [23:0] wdata);
    lat = 0; nrd = 0; nwr = 0; err = 1'b0; wdata = '0;
    @(negedge clk);
    cpu_if.req = 1'b1; cpu_if.req_write = wr; cpu_if.req_byte = by;
    cpu_if.req_signed = sg; cpu_if.req_addr = addr; cpu_if.req_lane = lane;
    cpu_if.store_data = sd;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) cpu_if.req = 1'b0;
      if (mem_read) nrd++;
      if (mem_write) begin nwr++; wdata = mem_wdata; end
      if (cpu_if.done) begin lat = k; err = cpu_if.error; break; end
    end
  endtask

  int          lat, nrd, nwr, dcnt, d1, d2;
  logic        err;
  logic [23:0] wd;

  initial begin
    n_tests = 0; n_fail = 0; overlap = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    cpu_if.req = 0; cpu_if.req_write = 0; cpu_if.req_byte = 0;
    cpu_if.req_signed = 0; cpu_if.req_addr = '0; cpu_if.req_lane = '0;
    cpu_if.store_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", cpu_if.busy, 0);
    check("rst_outs", {cpu_if.done, cpu_if.error, mem_write, mem_read}, 0);
    check("rst_load", cpu_if.load_data, 0);
    check("rst_mem", {mem_addr, mem_wdata}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;

    // Word store then load
    run_op(1, 0, 0, 24'd2, 2'd0, 24'd30, lat, nrd, nwr, err, wd);
    check("wst_lat", lat, 2);
    check("wst_strobes", {nrd[7:0], nwr[7:0]}, {8'd0, 8'd1});
    check("wst_wdata", wd, 24'd30);
    check("wst_mem", mem[2], 24'd30);
    run_op(0, 0, 0, 24'd2, 2'd0, 24'd0, lat, nrd, nwr, err, wd);
    check("wld_lat", lat, 2);
    check("wld_strobes", {nrd[7:0], nwr[7:0]}, {8'd1, 8'd0});
    check("wld_data", cpu_if.load_data, 24'd30);

    // Signed/unsigned byte loads
    mem[5] = 24'h807FC3;
    run_op(0, 1, 1, 24'd5, 2'd0, 24'd0, lat, nrd, nwr, err, wd);
    check("bld_l0s", cpu_if.load_data, 24'hFFFFC3);
    check("bld_lat", lat, 2);
    run_op(0, 1, 1, 24'd5, 2'd1, 24'd0, lat, nrd, nwr, err, wd);
    check("bld_l1s", cpu_if.load_data, 24'h00007F);
    run_op(0, 1, 0, 24'd5, 2'd2, 24'd0, lat, nrd, nwr, err, wd);
    check("bld_l2u", cpu_if.load_data, 24'h000080);
    run_op(0, 1, 0, 24'd5, 2'd0, 24'd0, lat, nrd, nwr, err, wd);
    check("bld_l0u", cpu_if.load_data, 24'h0000C3);

    // Byte store read-modify-write
    mem[7] = 24'h112233;
    run_op(1, 1, 0, 24'd7, 2'd1, 24'h0000AB, lat, nrd, nwr, err, wd);
    check("bst_lat", lat, 3);
    check("bst_strobes", {nrd[7:0], nwr[7:0]}, {8'd1, 8'd1});
    check("bst_wdata", wd, 24'h11AB33);
    check("bst_load_kept", cpu_if.load_data, 24'h0000C3);
    run_op(0, 0, 0, 24'd7, 2'd0, 24'd0, lat, nrd, nwr, err, wd);
    check("bst_readback", cpu_if.load_data, 24'h11AB33);
    mem[8] = 24'hA1B2C3;
    run_op(1, 1, 0, 24'd8, 2'd2, 24'h00005D, lat, nrd, nwr, err, wd);
    check("bst_l2_mem", mem[8], 24'h5DB2C3);

    // Illegal lane
    run_op(0, 1, 1, 24'd5, 2'd3, 24'd0, lat, nrd, nwr, err, wd);
    check("ill_lat", lat, 2);
    check("ill_strobes", {nrd[7:0], nwr[7:0]}, 0);
    check("ill_err", err, 1);
    check("ill_load_kept", cpu_if.load_data, 24'h11AB33);
    run_op(0, 0, 0, 24'd2, 2'd3, 24'd0, lat, nrd, nwr, err, wd);
    check("word_lane3_ok", {err, cpu_if.load_data}, {1'b0, 24'd30});

    // Reset during WRITE of a byte store
    mem[9] = 24'h000000;
    @(negedge clk);
    cpu_if.req = 1; cpu_if.req_write = 1; cpu_if.req_byte = 1;
    cpu_if.req_addr = 24'd9; cpu_if.req_lane = 2'd0; cpu_if.store_data = 24'h0000FF;
    @(negedge clk);
    cpu_if.req = 0;
    check("rmid_access_rd", mem_read, 1);
    @(negedge clk);
    check("rmid_write_on", {mem_write, mem_wdata}, {1'b1, 24'h0000FF});
    rst_n = 1'b0;
    #1;
    check("rmid_write_off", mem_write, 0);
    check("rmid_busy", cpu_if.busy, 0);
    check("rmid_outs", {cpu_if.done, cpu_if.error, mem_read, mem_wdata, mem_addr}, 0);
    check("rmid_load", cpu_if.load_data, 0);
    @(posedge clk); #1;
    check("rmid_mem9", mem[9], 24'h000000);
    @(negedge clk);
    rst_n = 1'b1;

    // Req pulsed while busy is ignored
    dcnt = 0;
    @(negedge clk);
    cpu_if.req = 1; cpu_if.req_write = 0; cpu_if.req_byte = 0; cpu_if.req_addr = 24'd2;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_in_access", cpu_if.busy, 1);
      if (k == 2) cpu_if.req = 0;
      if (cpu_if.done) dcnt++;
    end
    check("busy_one_done", dcnt, 1);

    // Req held high across DONE gives back-to-back operations
    dcnt = 0; d1 = 0; d2 = 0;
    @(negedge clk);
    cpu_if.req = 1; cpu_if.req_addr = 24'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 4) cpu_if.req = 0;
      if (cpu_if.done) begin
        dcnt++;
        if (dcnt == 1) d1 = k; else d2 = k;
      end
    end
    check("b2b_done_cnt", dcnt, 2);
    check("b2b_timing", {d1[7:0], d2[7:0]}, {8'd2, 8'd5});
    check("b2b_data", cpu_if.load_data, 24'h11AB33);

    check("no_rd_wr_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
